// File: rtl/graph_pkg.sv
// Shared types and widths for the graph traversal datapath.
package graph_pkg;
    localparam int COORD_W     = 16;
    localparam int DIM_DEFAULT = 4;
    localparam int DIST_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } state_t;
endpackage

// File: rtl/id_fifo.sv
// Pending vertex-id queue between the fetch-stage accept and the distance result.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
module id_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vertex_distance.sv
// Squared Euclidean distance from each fetched vertex position to a local query vector.
// Latency: 2*DIM cycles from first pos_deq_out to dist_valid_out with 1-cycle FIFO reads.
// Backpressure: result held until dist_ready_in; no dequeues while a result is pending.
module vertex_distance
    import graph_pkg::*;
#(
    parameter int DIM      = DIM_DEFAULT,
    parameter int ID_DEPTH = 4,
    localparam int IDX_W   = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              query_wr_in,
    input  logic [IDX_W-1:0]  query_idx_in,
    input  logic [31:0]       query_data_in,
    input  logic [31:0]       v_id_in,
    input  logic              v_id_valid_in,
    output logic              id_full_out,
    input  logic              pos_empty_in,
    output logic              pos_deq_out,
    input  logic [31:0]       pos_data_in,
    input  logic              pos_valid_in,
    output logic [31:0]       dist_id_out,
    output logic [DIST_W-1:0] dist_out,
    output logic              dist_valid_out,
    input  logic              dist_ready_in,
    output logic              busy_out
);
    localparam int SQ_W  = 2*COORD_W + 1;
    localparam int ACC_W = SQ_W + $clog2(DIM);

    state_t                     state_q;
    state_t                     state_d;
    logic [IDX_W-1:0]           cnt_q;
    logic [ACC_W-1:0]           acc_q;
    logic signed [COORD_W-1:0]  query_q [DIM];
    logic [31:0]                id_q;

    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       fifo_pop;
    logic [31:0]                fifo_head;

    logic                       acc_en;
    logic                       last_word;
    logic signed [COORD_W:0]    diff;
    logic signed [2*COORD_W+1:0] prod;
    logic [SQ_W-1:0]            sq;
    logic                       unused_bits;

    id_fifo #(
        .WIDTH (32),
        .DEPTH (ID_DEPTH)
    ) u_id_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (v_id_valid_in),
        .push_data (v_id_in),
        .pop       (fifo_pop),
        .data      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign id_full_out = fifo_full;
    assign busy_out    = (state_q != IDLE);
    assign last_word   = (cnt_q == IDX_W'(DIM-1));
    assign unused_bits = &{1'b0, pos_data_in[31:COORD_W], query_data_in[31:COORD_W]};

    // 17-bit difference cannot overflow; its square fits in 33 unsigned bits.
    assign diff = $signed({pos_data_in[COORD_W-1], pos_data_in[COORD_W-1:0]})
                - $signed({query_q[cnt_q][COORD_W-1], query_q[cnt_q]});
    assign prod = diff * diff;
    assign sq   = prod[SQ_W-1:0];

    assign dist_out    = (acc_q > ACC_W'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : acc_q[31:0];
    assign dist_id_out = id_q;

    always_comb begin
        state_d        = state_q;
        pos_deq_out    = 1'b0;
        dist_valid_out = 1'b0;
        fifo_pop       = 1'b0;
        acc_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !pos_empty_in) state_d = REQ;
            end
            REQ: begin
                if (!pos_empty_in) begin
                    pos_deq_out = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (pos_valid_in) begin
                    acc_en  = 1'b1;
                    state_d = last_word ? OUT : REQ;
                end
            end
            OUT: begin
                dist_valid_out = 1'b1;
                if (dist_ready_in) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            id_q    <= '0;
            for (int i = 0; i < DIM; i++) query_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (acc_en) begin
                acc_q <= acc_q + ACC_W'(sq);
                if (last_word) id_q <= fifo_head;
                else           cnt_q <= cnt_q + 1'b1;
            end
            if (fifo_pop) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
            if (query_wr_in && state_q == IDLE && int'(query_idx_in) < DIM) begin
                query_q[query_idx_in] <= query_data_in[COORD_W-1:0];
            end
        end
    end
endmodule
